// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES-128 constants and types.
//   AES_NR / AES_NK : round count and key length in words for AES-128.
//   LAST_RND        : AES_NR as a 4-bit round index.
//   rcon_t, RCON    : round constants; index 0 is unused padding.
//   round_key_t     : one 128-bit round key, w0 in the top 32 bits.
//   SBOX            : forward S-box, also used by the encrypt SubBytes.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;
    localparam logic [3:0] LAST_RND = 4'(AES_NR);

    typedef logic [7:0]   rcon_t;
    typedef logic [127:0] round_key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    localparam rcon_t RCON [0:AES_NR] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox -- combinational AES forward S-box lookup.
//   byte_i : input byte
//   byte_o : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand -- iterative AES-128 key schedule, one round key per clock.
// Loads the cipher key on start, generates round keys 1..10 and keeps all 11
// for indexed reads by the round logic.
//   clk, reset        : clock, synchronous active-high reset
//   start, key        : start pulse (honoured only when idle) and cipher key
//   busy, done        : expansion running / all round keys valid (sticky)
//   rk_idx, rk        : round-key select and registered round key
//   rk_valid          : registered, done and rk_idx in range
// Optional macro AES_KEYEXP_STREAM_EN adds rks_vld / rks_idx / rks_key, a
// registered copy of every round-key write (including round 0 at start).
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk,
    output logic         rk_valid
`ifdef AES_KEYEXP_STREAM_EN
    ,
    output logic         rks_vld,
    output logic [3:0]   rks_idx,
    output logic [127:0] rks_key
`endif
);

    ks_state_e  state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    round_key_t rk_mem_q [0:AES_NR];
    round_key_t rk_q, rk_d;
    logic       rk_valid_q, rk_valid_d;

    logic       wr_en;
    logic [3:0] wr_idx;
    round_key_t wr_key;

    // Round datapath: previous key -> RotWord -> SubWord -> Rcon -> XOR chain
    logic [3:0]  prev_idx;
    round_key_t  prev_key;
    logic [31:0] rot_word, sub_word, temp;
    logic [31:0] w0n, w1n, w2n, w3n;
    round_key_t  next_key;

    assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
    assign prev_key = rk_mem_q[prev_idx];
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar g = 0; g < AES_NK; g++) begin : g_subword
        aes_sbox u_sbox (
            .byte_i (rot_word[8*g +: 8]),
            .byte_o (sub_word[8*g +: 8])
        );
    end

    // rnd_q is held in 0..10, so the Rcon index never leaves the table.
    assign temp     = sub_word ^ {RCON[rnd_q], 24'h0};
    assign w0n      = prev_key[127:96] ^ temp;
    assign w1n      = prev_key[95:64]  ^ w0n;
    assign w2n      = prev_key[63:32]  ^ w1n;
    assign w3n      = prev_key[31:0]   ^ w2n;
    assign next_key = {w0n, w1n, w2n, w3n};

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (rnd_q == LAST_RND) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs (next values of counter, flags and round-key write)
    always_comb begin
        rnd_d  = rnd_q;
        busy_d = busy_q;
        done_d = done_q;
        wr_en  = 1'b0;
        wr_idx = rnd_q;
        wr_key = next_key;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rnd_d  = 4'd1;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    wr_en  = 1'b1;
                    wr_idx = 4'd0;
                    wr_key = key;
                end
            end
            ST_RUN: begin
                wr_en = 1'b1;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    // Park the counter at 0 so it stays inside the Rcon table.
                    rnd_d  = 4'd0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_q  <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rnd_q  <= rnd_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= AES_NR; i++) rk_mem_q[i] <= '0;
        end else if (wr_en) begin
            rk_mem_q[wr_idx] <= wr_key;
        end
    end

    // Read port: out-of-range indices return zero and are never valid.
    logic       idx_ok;
    logic [3:0] rd_idx;
    assign idx_ok     = (rk_idx <= LAST_RND);
    assign rd_idx     = idx_ok ? rk_idx : 4'd0;
    assign rk_d       = idx_ok ? rk_mem_q[rd_idx] : '0;
    assign rk_valid_d = done_q & idx_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rk       = rk_q;
    assign rk_valid = rk_valid_q;

`ifdef AES_KEYEXP_STREAM_EN
    logic       rks_vld_q;
    logic [3:0] rks_idx_q;
    round_key_t rks_key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rks_vld_q <= 1'b0;
            rks_idx_q <= 4'd0;
            rks_key_q <= '0;
        end else begin
            rks_vld_q <= wr_en;
            if (wr_en) begin
                rks_idx_q <= wr_idx;
                rks_key_q <= wr_key;
            end
        end
    end

    assign rks_vld = rks_vld_q;
    assign rks_idx = rks_idx_q;
    assign rks_key = rks_key_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand -- directed self-checking bench for aes_key_expand.
// Also exercises the stream outputs when AES_KEYEXP_STREAM_EN is defined.
module tb_aes_key_expand;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         rk_valid;
`ifdef AES_KEYEXP_STREAM_EN
    logic         rks_vld;
    logic [3:0]   rks_idx;
    logic [127:0] rks_key;
`endif

    aes_key_expand dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .done     (done),
        .rk_idx   (rk_idx),
        .rk       (rk),
        .rk_valid (rk_valid)
`ifdef AES_KEYEXP_STREAM_EN
        ,
        .rks_vld  (rks_vld),
        .rks_idx  (rks_idx),
        .rks_key  (rks_key)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z  = 128'h0;
    localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until done rises (bounded). Optionally pulses start with k2 so
    // that it is sampled at edge N+pulse_at, N being the accepting edge.
    task automatic wait_done(input int pulse_at, input logic [127:0] k2, output int lat);
        lat = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            start = 1'b0;
            if (i == pulse_at - 1) begin
                start = 1'b1;
                key   = k2;
            end
            if (i == 5) chk("rd_run_vld", {127'b0, rk_valid}, 128'd0);
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp_rk,
                      input logic exp_vld, input string tag);
        rk_idx = idx;
        step();
        chk({tag, "_rk"},  rk, exp_rk);
        chk({tag, "_vld"}, {127'b0, rk_valid}, {127'b0, exp_vld});
    endtask

`ifdef AES_KEYEXP_STREAM_EN
    int           s_cnt = 0;
    logic [3:0]   s_idx [0:15];
    logic [127:0] s_key [0:15];
    always @(negedge clk) begin
        if (rks_vld && s_cnt < 16) begin
            s_idx[s_cnt] = rks_idx;
            s_key[s_cnt] = rks_key;
            s_cnt        = s_cnt + 1;
        end
    end
`endif

    initial begin
        int lat;
        reset  = 1'b1;
        start  = 1'b0;
        key    = '0;
        rk_idx = 4'd0;
        step();
        step();
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_done", {127'b0, done}, 128'd0);
        chk("rst_rk", rk, 128'd0);
        chk("rst_vld", {127'b0, rk_valid}, 128'd0);
        reset = 1'b0;

        // App. A key, plain run
`ifdef AES_KEYEXP_STREAM_EN
        s_cnt = 0;
`endif
        key   = KEY_A;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("a_busy_start", {127'b0, busy}, 128'd1);
        wait_done(0, KEY_A, lat);
        chk("a_latency", 128'(lat), 128'd10);
        chk("a_busy_end", {127'b0, busy}, 128'd0);
        rd(4'd0,  KEY_A,  1'b1, "a_rk0");
        rd(4'd1,  A_RK1,  1'b1, "a_rk1");
        rd(4'd2,  A_RK2,  1'b1, "a_rk2");
        rd(4'd10, A_RK10, 1'b1, "a_rk10");
        rd(4'd11, 128'd0, 1'b0, "a_idx11");
        rd(4'd15, 128'd0, 1'b0, "a_idx15");
`ifdef AES_KEYEXP_STREAM_EN
        chk("s_count", 128'(s_cnt), 128'd11);
        for (int i = 0; i < 11; i++) chk("s_idx", {124'b0, s_idx[i]}, 128'(i));
        chk("s_key0",  s_key[0],  KEY_A);
        chk("s_key1",  s_key[1],  A_RK1);
        chk("s_key2",  s_key[2],  A_RK2);
        chk("s_key10", s_key[10], A_RK10);
`endif

        // All-zero key, with a stray start (key A) at N+3 that must be ignored
        key   = KEY_Z;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("z_done_drop", {127'b0, done}, 128'd0);
        wait_done(3, KEY_A, lat);
        chk("z_latency", 128'(lat), 128'd10);
        rd(4'd1,  Z_RK1,  1'b1, "z_rk1");
        rd(4'd10, Z_RK10, 1'b1, "z_rk10");
        rd(4'd0,  KEY_Z,  1'b1, "z_rk0");

        // Reset sampled at N+5 discards the run
        key   = KEY_A;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_busy", {127'b0, busy}, 128'd0);
        chk("mr_done", {127'b0, done}, 128'd0);
        chk("mr_rk", rk, 128'd0);
        rd(4'd1, 128'd0, 1'b0, "mr_mem1");

        // Fresh run after the reset completes normally
        key   = KEY_A;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, KEY_A, lat);
        chk("post_latency", 128'(lat), 128'd10);
        rd(4'd10, A_RK10, 1'b1, "post_rk10");
        rd(4'd1,  A_RK1,  1'b1, "post_rk1");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
